// File: rtl/tdm_pkg.sv
// Shared TDM link constants: frame size, slot-index width and receiver state encoding.
// Used by both the transmit sequencer and the receive demux so slot order agrees.
package tdm_pkg;

   localparam int unsigned TDM_NCH = 4;
   localparam int unsigned TDM_SW  = 2;

   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } tdm_state_t;

endpackage

// File: rtl/tdm_demux_1_4.sv
// Receive side of the 4:1 TDM link: follows the slot sweep, rebuilds the parallel
// word, strobes dout_valid per complete frame and pulses sync_err on framing violations.
module tdm_demux_1_4
   import tdm_pkg::*;
#(
   parameter int unsigned NCH = TDM_NCH,
   parameter int unsigned SW  = TDM_SW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           din_valid,
   input  logic           frame_sync,
   input  logic           din,
   output logic [NCH-1:0] dout,
   output logic           dout_valid,
   output logic [SW-1:0]  slot,
   output logic           sync_err
);

   localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);
   localparam logic [SW-1:0] ONE_SLOT  = SW'(1);

   tdm_state_t     state_q, state_d;
   logic [SW-1:0]  slot_q, slot_d;
   logic [NCH-1:0] shadow_q, shadow_d;
   logic [NCH-1:0] dout_q, dout_d;
   logic           dv_q, dv_d;
   logic           err_q, err_d;

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      shadow_d = shadow_q;
      dout_d   = dout_q;
      dv_d     = 1'b0;
      err_d    = 1'b0;
      if (din_valid) begin
         unique case (state_q)
            HUNT: begin
               if (frame_sync) begin
                  shadow_d[0] = din;
                  slot_d      = ONE_SLOT;
                  state_d     = RECV;
               end
            end
            RECV: begin
               if (slot_q == '0) begin
                  if (frame_sync) begin
                     shadow_d[0] = din;
                     slot_d      = ONE_SLOT;
                  end else begin
                     err_d    = 1'b1;
                     shadow_d = '0;
                     slot_d   = '0;
                     state_d  = HUNT;
                  end
               end else if (frame_sync) begin
                  // Early sync mid-frame: drop the partial frame and restart at slot 0.
                  err_d       = 1'b1;
                  shadow_d    = '0;
                  shadow_d[0] = din;
                  slot_d      = ONE_SLOT;
               end else begin
                  shadow_d[slot_q] = din;
                  if (slot_q == LAST_SLOT) begin
                     dout_d = shadow_d;
                     dv_d   = 1'b1;
                     slot_d = '0;
                  end else begin
                     slot_d = slot_q + ONE_SLOT;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= HUNT;
         slot_q   <= '0;
         shadow_q <= '0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         shadow_q <= shadow_d;
         dout_q   <= dout_d;
         dv_q     <= dv_d;
         err_q    <= err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dv_q;
   assign slot       = slot_q;
   assign sync_err   = err_q;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Self-checking bench for tdm_demux_1_4: directed frames plus random beats,
// compared against a queue-based frame-assembly model.
module tb_tdm_demux_1_4;

   localparam int NCH = 4;
   localparam int SW  = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           din_valid = 1'b0;
   logic           frame_sync = 1'b0;
   logic           din = 1'b0;
   logic [NCH-1:0] dout;
   logic           dout_valid;
   logic [SW-1:0]  slot;
   logic           sync_err;

   int checks = 0;
   int errors = 0;

   // Reference model: hunting flag plus the bits gathered so far in the current frame.
   bit             m_hunt = 1'b1;
   bit             m_bits[$];
   logic [NCH-1:0] m_dout = '0;
   bit             m_dv = 1'b0;
   bit             m_err = 1'b0;

   tdm_demux_1_4 dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .slot       (slot),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int m_slot();
      return m_hunt ? 0 : m_bits.size();
   endfunction

   task automatic model_reset();
      m_hunt = 1'b1;
      m_bits.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic model_step(input bit v, input bit fs, input bit d);
      m_dv  = 1'b0;
      m_err = 1'b0;
      if (!v) return;
      if (m_hunt) begin
         if (fs) begin
            m_bits = {d};
            m_hunt = 1'b0;
         end
      end else if (m_bits.size() == 0) begin
         if (fs) m_bits = {d};
         else begin
            m_err  = 1'b1;
            m_hunt = 1'b1;
         end
      end else if (fs) begin
         m_err  = 1'b1;
         m_bits = {d};
      end else begin
         m_bits.push_back(d);
         if (m_bits.size() == NCH) begin
            for (int k = 0; k < NCH; k++) m_dout[k] = m_bits[k];
            m_dv = 1'b1;
            m_bits.delete();
         end
      end
   endtask

   task automatic beat(input bit v, input bit fs, input bit d);
      @(negedge clk);
      din_valid  = v;
      frame_sync = fs;
      din        = d;
      model_step(v, fs, d);
      @(posedge clk);
      #1;
      chk("dout", 32'(dout), 32'(m_dout));
      chk("dout_valid", 32'(dout_valid), 32'(m_dv));
      chk("sync_err", 32'(sync_err), 32'(m_err));
      chk("slot", 32'(slot), 32'(m_slot()));
   endtask

   task automatic frame(input logic [NCH-1:0] w);
      for (int k = 0; k < NCH; k++) beat(1'b1, k == 0, w[k]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      #12;
      chk("reset dout", 32'(dout), 32'h0);
      chk("reset dout_valid", 32'(dout_valid), 32'h0);
      chk("reset sync_err", 32'(sync_err), 32'h0);
      chk("reset slot", 32'(slot), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Single frame 0,0,1,0 -> 4'b0100
      frame(4'b0100);
      chk("frame0100", 32'(dout), 32'h4);
      idle(1);
      chk("dv pulse width", 32'(dout_valid), 32'h0);

      // Back-to-back 0101 then 1100 with a 3-cycle gap inside the second frame
      frame(4'b0101);
      chk("frame0101", 32'(dout), 32'h5);
      beat(1'b1, 1'b1, 1'b0);
      beat(1'b1, 1'b0, 1'b0);
      idle(3);
      beat(1'b1, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b1);
      chk("frame1100 gap", 32'(dout), 32'hC);

      // Non-sync beat at slot 0 -> error, back to HUNT, dout holds
      beat(1'b1, 1'b0, 1'b1);
      chk("slot0 err", 32'(sync_err), 32'h1);
      chk("dout held", 32'(dout), 32'hC);

      // HUNT ignores non-sync beats without error
      for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'($urandom_range(1)));
      frame(4'b1100);
      chk("hunt then 1100", 32'(dout), 32'hC);

      // Early sync on 3rd beat: resync, then 1,0,1,0 from that beat -> 4'b0101
      beat(1'b1, 1'b1, 1'b0);
      beat(1'b1, 1'b0, 1'b1);
      beat(1'b1, 1'b1, 1'b1);
      chk("early sync err", 32'(sync_err), 32'h1);
      beat(1'b1, 1'b0, 1'b0);
      beat(1'b1, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b0);
      chk("resync frame", 32'(dout), 32'h5);

      // Sync at last slot is a violation, no dout_valid
      beat(1'b1, 1'b1, 1'b1);
      beat(1'b1, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b1);
      beat(1'b1, 1'b1, 1'b0);
      chk("last-slot sync err", 32'(sync_err), 32'h1);
      chk("last-slot no dv", 32'(dout_valid), 32'h0);

      // Async reset mid-frame, no clock edge needed
      frame(4'b0011);
      beat(1'b1, 1'b1, 1'b1);
      beat(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      din_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("async rst dout", 32'(dout), 32'h0);
      chk("async rst slot", 32'(slot), 32'h0);
      chk("async rst dv", 32'(dout_valid), 32'h0);
      chk("async rst err", 32'(sync_err), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      frame(4'b1010);
      chk("after rst frame", 32'(dout), 32'hA);

      // Random beats, sync biased towards frame starts
      for (int i = 0; i < 400; i++) begin
         bit v, fs, d;
         v  = ($urandom_range(3) != 0);
         fs = (m_slot() == 0) ? ($urandom_range(9) != 0) : ($urandom_range(11) == 0);
         d  = 1'($urandom_range(1));
         beat(v, fs, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
